ram_bist_ctrl: RTL

Built-in self-test initiator for the 16x8 single-port RAM. It drives the RAM's RW_en/addr/din port and consumes its dout. It runs a four-pass march (write pattern, read/compare, write inverse, read/compare) and reports pass/fail, the failure count and the first failing location. It sits beside the RAM instance and muxes onto the RAM port only while busy; the mux is outside this block.

---
 rtl/ram_bist_pkg.sv | 25 ++
 rtl/ram_bist_cmp.sv | 62 ++++++
 rtl/ram_bist_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ram_bist_pkg.sv
// rtl/ram_bist_pkg.sv - shared types and helpers for the RAM march BIST
package ram_bist_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR0,
        RD0,
        WR1,
        RD1,
        DRAIN,
        DONE
    } state_t;

    localparam logic [7:0] DEFAULT_PATTERN = 8'hA5;

    // Expected word is the pattern XOR the zero-extended address; callers truncate to DATA_W.
    function automatic logic [31:0] exp_word(input logic [31:0] pattern,
                                             input logic [31:0] addr,
                                             input logic        inv);
        logic [31:0] w;
        w = pattern ^ addr;
        return inv ? ~w : w;
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// rtl/ram_bist_cmp.sv - read-data compare stage, saturating fail counter, first-fail capture
module ram_bist_cmp
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              rd_issue,
    input  logic              rd_phase,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              hit,
    output logic [ADDR_W+1:0] fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              first_fail_phase
);

    localparam logic [ADDR_W+1:0] FAIL_MAX = (ADDR_W+2)'(2 * (2 ** ADDR_W));

    logic              stg_valid;
    logic              stg_phase;
    logic [ADDR_W-1:0] stg_addr;
    logic [DATA_W-1:0] stg_exp;

    // The stage holds the read that the RAM is answering this cycle.
    assign hit = stg_valid && (ram_dout != stg_exp);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_valid        <= 1'b0;
            stg_phase        <= 1'b0;
            stg_addr         <= '0;
            stg_exp          <= '0;
            fail_count       <= '0;
            first_fail_addr  <= '0;
            first_fail_phase <= 1'b0;
        end else begin
            stg_valid <= rd_issue;
            stg_phase <= rd_phase;
            stg_addr  <= rd_addr;
            stg_exp   <= DATA_W'(exp_word(32'(PATTERN), 32'(rd_addr), rd_phase));
            if (clear) begin
                fail_count       <= '0;
                first_fail_addr  <= '0;
                first_fail_phase <= 1'b0;
            end else if (hit) begin
                if (fail_count != FAIL_MAX) begin
                    fail_count <= fail_count + 1'b1;
                end
                if (fail_count == '0) begin
                    first_fail_addr  <= stg_addr;
                    first_fail_phase <= stg_phase;
                end
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - four-pass march BIST initiator for a single-port RAM
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int                ADDR_W  = 4,
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] PATTERN = DATA_W'(DEFAULT_PATTERN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ram_rw_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR_W+1:0] fail_count,
    output logic [ADDR_W-1:0] first_fail_addr,
    output logic              first_fail_phase
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] cnt, cnt_nxt;
    logic              accept;
    logic              last;
    logic              rw_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] din_nxt;
    logic              issue_nxt, phase_nxt;
    logic              rd_issue, rd_phase;
    logic              hit;

    assign last   = (cnt == '1);
    assign accept = start && ((state == IDLE) || (state == DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Port values are computed from the current state and registered, so the RAM sees each access one cycle later.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rw_nxt    = 1'b1;
        addr_nxt  = '0;
        din_nxt   = '0;
        issue_nxt = 1'b0;
        phase_nxt = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = WR0;
                    cnt_nxt   = '0;
                end
            end
            WR0: begin
                cnt_nxt  = cnt + 1'b1;
                rw_nxt   = 1'b0;
                addr_nxt = cnt;
                din_nxt  = DATA_W'(exp_word(32'(PATTERN), 32'(cnt), 1'b0));
                if (last) state_nxt = RD0;
            end
            RD0: begin
                cnt_nxt   = cnt + 1'b1;
                addr_nxt  = cnt;
                issue_nxt = 1'b1;
                if (last) state_nxt = WR1;
            end
            WR1: begin
                cnt_nxt  = cnt + 1'b1;
                rw_nxt   = 1'b0;
                addr_nxt = cnt;
                din_nxt  = DATA_W'(exp_word(32'(PATTERN), 32'(cnt), 1'b1));
                if (last) state_nxt = RD1;
            end
            RD1: begin
                cnt_nxt   = cnt + 1'b1;
                addr_nxt  = cnt;
                issue_nxt = 1'b1;
                phase_nxt = 1'b1;
                if (last) state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = DONE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ram_rw_en <= 1'b1;
            ram_addr  <= '0;
            ram_din   <= '0;
            rd_issue  <= 1'b0;
            rd_phase  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            ram_rw_en <= rw_nxt;
            ram_addr  <= addr_nxt;
            ram_din   <= din_nxt;
            rd_issue  <= issue_nxt;
            rd_phase  <= phase_nxt;
            if (accept) begin
                busy <= 1'b1;
                done <= 1'b0;
                pass <= 1'b0;
            end else if (state == DONE) begin
                // The final RD1 compare resolves on this same edge, so fold it into pass.
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (fail_count == '0) && !hit;
            end
        end
    end

    ram_bist_cmp #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .PATTERN(PATTERN)
    ) u_cmp (
        .clk             (clk),
        .rst             (rst),
        .clear           (accept),
        .rd_issue        (rd_issue),
        .rd_phase        (rd_phase),
        .rd_addr         (ram_addr),
        .ram_dout        (ram_dout),
        .hit             (hit),
        .fail_count      (fail_count),
        .first_fail_addr (first_fail_addr),
        .first_fail_phase(first_fail_phase)
    );

endmodule
